// File: rtl/fb_pixel_writer_if.sv
// Pixel stream in / framebuffer write port out for fb_pixel_writer.
// The slave modport is the writer's view; master is the upstream/BRAM side.
interface fb_pixel_writer_if #(
    parameter int ADDR_WIDTH = 17
);
    logic [23:0]           pixel_axis_tdata;
    logic                  pixel_axis_tvalid;
    logic                  pixel_axis_tready;
    logic [ADDR_WIDTH-1:0] fb_addr;
    logic [15:0]           fb_data;
    logic                  fb_we;

    modport master (
        output pixel_axis_tdata, pixel_axis_tvalid,
        input  pixel_axis_tready, fb_addr, fb_data, fb_we
    );

    modport slave (
        input  pixel_axis_tdata, pixel_axis_tvalid,
        output pixel_axis_tready, fb_addr, fb_data, fb_we
    );
endinterface

// File: rtl/fb_pixel_writer.sv
// Framebuffer writer: takes one raster-order RGB888 frame per start pulse,
// packs each pixel to RGB565 and writes it at a linearly incrementing address.
module fb_pixel_writer #(
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int ADDR_WIDTH = 17
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               start,
    fb_pixel_writer_if.slave   bus,
    output logic               busy,
    output logic               frame_done,
    output logic [7:0]         frame_count
);
    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                state, state_nxt;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  accept;
    logic                  last_beat;
    logic                  unused_lsbs;

    assign accept    = bus.pixel_axis_tvalid & bus.pixel_axis_tready;
    assign last_beat = (x == XW'(H_RES - 1)) && (y == YW'(V_RES - 1));

    // Low colour bits are truncated by the RGB565 packing.
    assign unused_lsbs = ^{bus.pixel_axis_tdata[18:16], bus.pixel_axis_tdata[9:8],
                           bus.pixel_axis_tdata[2:0]};

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state: start arms a frame, the final accepted beat ends it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)                 state_nxt = WRITE;
            WRITE:   if (accept && last_beat)   state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    // Ready depends on state only, so tvalid never reaches tready.
    always_comb begin
        bus.pixel_axis_tready = 1'b0;
        if (state == WRITE) bus.pixel_axis_tready = 1'b1;
    end

    // Raster position and address; cleared on start and after the last pixel
    // so the address register never runs past the frame.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (state == IDLE && start) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (accept) begin
            if (last_beat) begin
                x    <= '0;
                y    <= '0;
                addr <= '0;
            end else begin
                addr <= addr + ADDR_WIDTH'(1);
                if (x == XW'(H_RES - 1)) begin
                    x <= '0;
                    y <= y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end
        end
    end

    // Write port and status, all registered one cycle after acceptance.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bus.fb_we   <= 1'b0;
            bus.fb_addr <= '0;
            bus.fb_data <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            busy        <= 1'b0;
        end else begin
            bus.fb_we  <= accept;
            frame_done <= accept & last_beat;
            // Busy covers the frame_done cycle; a start taken then keeps it high.
            busy       <= (state_nxt == WRITE) | (accept & last_beat);
            if (accept) begin
                bus.fb_addr <= addr;
                bus.fb_data <= {bus.pixel_axis_tdata[23:19],
                                bus.pixel_axis_tdata[15:10],
                                bus.pixel_axis_tdata[7:3]};
            end
            if (accept && last_beat) frame_count <= frame_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer on a 4x2 frame.
module tb_fb_pixel_writer;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 17;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic       frame_done;
    logic [7:0] frame_count;

    fb_pixel_writer_if #(.ADDR_WIDTH(AW)) bus ();

    fb_pixel_writer #(.H_RES(H), .V_RES(V), .ADDR_WIDTH(AW)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .start       (start),
        .bus         (bus.slave),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    always #5 aclk = ~aclk;

    logic [23:0] pix   [8] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF,
                               24'h123456, 24'h123456, 24'h123456, 24'h123456};
    // {R[7:3],G[7:2],B[7:3]}: 0x123456 -> 00010,001101,01010 = 0x11AA
    logic [15:0] exp16 [8] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF,
                               16'h11AA, 16'h11AA, 16'h11AA, 16'h11AA};

    int n_chk = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    // Write/done event counters sampled mid-cycle.
    always @(negedge aclk) begin
        if (bus.fb_we === 1'b1)  wr_cnt   <= wr_cnt + 1;
        if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        start   = 1'b0;
        bus.pixel_axis_tvalid = 1'b0;
        bus.pixel_axis_tdata  = '0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    task automatic start_frame();
        start = 1'b1;
        @(posedge aclk);
        #1;
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_tready", 32'(bus.pixel_axis_tready), 32'd1);
    endtask

    // mode 0: tvalid always high; mode 1: tvalid 1,0,0,1,0,0,...
    // extra_start pulses start with the 3rd and 8th beat.
    task automatic feed(input int n, input int mode, input bit extra_start);
        int k   = 0;
        int cyc = 0;
        bit acc;
        while (k < n && cyc < 100) begin
            bus.pixel_axis_tvalid = (mode == 0) || (cyc % 3 == 0);
            bus.pixel_axis_tdata  = pix[k];
            start = extra_start && bus.pixel_axis_tvalid && (k == 2 || k == 7);
            acc   = bus.pixel_axis_tvalid && bus.pixel_axis_tready;
            @(posedge aclk);
            #1;
            if (acc) begin
                chk("wr_we",   32'(bus.fb_we),   32'd1);
                chk("wr_addr", 32'(bus.fb_addr), 32'(k));
                chk("wr_data", 32'(bus.fb_data), 32'(exp16[k]));
                chk("wr_done", 32'(frame_done),  32'(k == H*V-1));
                k++;
            end else begin
                chk("stall_we", 32'(bus.fb_we), 32'd0);
            end
            cyc++;
        end
        bus.pixel_axis_tvalid = 1'b0;
        start = 1'b0;
        chk("feed_beats", 32'(k), 32'(n));
    endtask

    task automatic end_of_frame(input int fc);
        chk("eof_tready", 32'(bus.pixel_axis_tready), 32'd0);
        chk("eof_busy",   32'(busy),                  32'd1);
        chk("eof_fcount", 32'(frame_count),           32'(fc));
        @(posedge aclk);
        #1;
        chk("post_busy", 32'(busy),       32'd0);
        chk("post_we",   32'(bus.fb_we),  32'd0);
        chk("post_done", 32'(frame_done), 32'd0);
    endtask

    initial begin
        int w0, d0;
        do_reset();

        // Reset values
        chk("rst_we",     32'(bus.fb_we),             32'd0);
        chk("rst_addr",   32'(bus.fb_addr),           32'd0);
        chk("rst_data",   32'(bus.fb_data),           32'd0);
        chk("rst_tready", 32'(bus.pixel_axis_tready), 32'd0);
        chk("rst_busy",   32'(busy),                  32'd0);
        chk("rst_done",   32'(frame_done),            32'd0);
        chk("rst_fcount", 32'(frame_count),           32'd0);

        // tvalid without start: nothing accepted
        bus.pixel_axis_tvalid = 1'b1;
        bus.pixel_axis_tdata  = pix[0];
        repeat (10) begin
            chk("idle_tready", 32'(bus.pixel_axis_tready), 32'd0);
            @(posedge aclk);
            #1;
            chk("idle_we",   32'(bus.fb_we), 32'd0);
            chk("idle_busy", 32'(busy),      32'd0);
        end
        bus.pixel_axis_tvalid = 1'b0;

        // Full continuous frame
        w0 = wr_cnt; d0 = done_cnt;
        start_frame();
        feed(8, 0, 1'b0);
        end_of_frame(1);
        chk("full_writes", 32'(wr_cnt - w0),   32'd8);
        chk("full_dones",  32'(done_cnt - d0), 32'd1);

        // Stalled frame
        do_reset();
        w0 = wr_cnt; d0 = done_cnt;
        start_frame();
        feed(8, 1, 1'b0);
        end_of_frame(1);
        chk("stall_writes", 32'(wr_cnt - w0),   32'd8);
        chk("stall_dones",  32'(done_cnt - d0), 32'd1);

        // Starts during the frame and on the final beat are ignored
        do_reset();
        start_frame();
        feed(8, 0, 1'b1);
        end_of_frame(1);
        w0 = wr_cnt;
        bus.pixel_axis_tvalid = 1'b1;
        repeat (5) begin
            chk("ign_tready", 32'(bus.pixel_axis_tready), 32'd0);
            @(posedge aclk);
            #1;
        end
        bus.pixel_axis_tvalid = 1'b0;
        chk("ign_writes", 32'(wr_cnt - w0),  32'd0);
        chk("ign_fcount", 32'(frame_count),  32'd1);

        // Back-to-back: start in the frame_done cycle
        do_reset();
        start_frame();
        feed(8, 0, 1'b0);
        chk("b2b_done1", 32'(frame_done), 32'd1);
        start_frame();
        feed(8, 0, 1'b0);
        end_of_frame(2);

        // Async reset mid-frame
        do_reset();
        start_frame();
        feed(5, 0, 1'b0);
        #2;
        aresetn = 1'b0;
        #1;
        chk("mrst_we",     32'(bus.fb_we),             32'd0);
        chk("mrst_addr",   32'(bus.fb_addr),           32'd0);
        chk("mrst_data",   32'(bus.fb_data),           32'd0);
        chk("mrst_tready", 32'(bus.pixel_axis_tready), 32'd0);
        chk("mrst_busy",   32'(busy),                  32'd0);
        chk("mrst_fcount", 32'(frame_count),           32'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        bus.pixel_axis_tvalid = 1'b1;
        repeat (3) begin
            @(posedge aclk);
            #1;
            chk("mrst_idle_we", 32'(bus.fb_we), 32'd0);
        end
        bus.pixel_axis_tvalid = 1'b0;
        start_frame();
        feed(8, 0, 1'b0);
        end_of_frame(1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end
endmodule
